// File: rtl/sim_status_writer.sv
// sim_status_writer
// End-of-test status path. While running it counts cycles and waits for either
// a status request from the design or a watchdog expiry. Whichever comes first
// is latched as the exit code. The block then drains for a fixed number of
// cycles, reports once and halts until the next reset. Only the report print
// and the optional $finish are simulation-only. The state machine and all
// outputs remain in synthesis.

module sim_status_writer #(
    parameter int unsigned CNT_W        = 64,
    parameter int unsigned DRAIN_CYCLES = 16,
    parameter logic [31:0] TIMEOUT_CODE = 32'hDEAD0001,
    parameter bit          FINISH       = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [CNT_W-1:0]  timeout_limit,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_code,
    output logic              done,
    output logic [31:0]       exit_code,
    output logic [CNT_W-1:0]  cycle_count
);

    // The drain counter only has to hold DRAIN_CYCLES. It keeps one bit
    // even when draining is disabled, so that the register is never zero-width.
    localparam int unsigned     DRN_W    = (DRAIN_CYCLES < 32'd1) ? 1 : $clog2(DRAIN_CYCLES + 32'd1);
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYCLES);
    localparam logic [DRN_W-1:0] DRN_ONE  = DRN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_REPORT = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DRN_W-1:0]   r_drn_cnt;
    logic [DRN_W-1:0]   w_drn_nxt;
    logic [CNT_W-1:0]   r_cycle_count;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [31:0]        r_exit_code;
    logic [31:0]        w_code_nxt;
    logic               r_req_ready;
    logic               r_done;
    logic               w_accept;
    logic               w_timeout;

    // Next-state, drain counter, cycle counter and exit code selection.
    always_comb begin
        w_state_nxt = r_state;
        w_drn_nxt   = r_drn_cnt;
        w_cnt_nxt   = r_cycle_count;
        w_code_nxt  = r_exit_code;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_RUN: begin
                // Ready is always high in RUN, so a valid request is a handshake.
                w_accept  = req_valid;
                // A limit of zero disables the watchdog. The equality test
                // means that a limit already passed never fires.
                w_timeout = (timeout_limit != CNT_ZERO) && (r_cycle_count == timeout_limit);
                if (w_accept || w_timeout) begin
                    // An accepted request takes priority over a simultaneous timeout.
                    if (w_accept) begin
                        w_code_nxt = req_code;
                    end else begin
                        w_code_nxt = TIMEOUT_CODE;
                    end
                    w_drn_nxt = DRN_LOAD;
                    if (DRAIN_CYCLES == 32'd0) begin
                        w_state_nxt = ST_REPORT;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                    // The counter freezes on the cycle that leaves RUN.
                end else begin
                    if (r_cycle_count != CNT_MAX) begin
                        w_cnt_nxt = r_cycle_count + CNT_ONE;
                    end else begin
                        w_cnt_nxt = r_cycle_count;
                    end
                end
            end
            ST_DRAIN: begin
                w_drn_nxt = r_drn_cnt - DRN_ONE;
                // A value of one or less ends the drain. The value zero cannot
                // occur here, but it still leads to REPORT so the FSM can never stall.
                if (r_drn_cnt <= DRN_ONE) begin
                    w_state_nxt = ST_REPORT;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_REPORT: begin
                w_state_nxt = ST_HALT;
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // State, counters and latched code. An asynchronous reset returns every register to the RUN values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_RUN;
            r_drn_cnt     <= {DRN_W{1'b0}};
            r_cycle_count <= CNT_ZERO;
            r_exit_code   <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_drn_cnt     <= w_drn_nxt;
            r_cycle_count <= w_cnt_nxt;
            r_exit_code   <= w_code_nxt;
        end
    end

    // Handshake and done flags. These registers are decoded from the next state and change on the same edge as r_state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_req_ready <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_req_ready <= (w_state_nxt == ST_RUN);
            r_done      <= (w_state_nxt == ST_HALT);
        end
    end

    assign req_ready   = r_req_ready;
    assign done        = r_done;
    assign exit_code   = r_exit_code;
    assign cycle_count = r_cycle_count;

`ifndef SYNTHESIS
    // Print the status record once at the edge that leaves REPORT. Reset suppresses the record.
    always_ff @(posedge clk) begin
        if (rstn && (r_state == ST_REPORT)) begin
            $display("[sim_status] code=%0h cycles=%0d", r_exit_code, r_cycle_count);
            if (FINISH) begin
                $finish;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sim_status_writer.sv
// tb_sim_status_writer
// Two instances share the clock and the reset: A with a drain of 4 cycles and
// B with no drain. Both run with FINISH=0 so that the bench keeps control.
// Each case fills per-cycle plans for valid, code and limit. A reference model
// finds the first cycle k in which a request is presented, or in which a
// nonzero limit equals k. Every output is derived from that cycle and checked
// on every falling edge.

module tb_sim_status_writer;

    localparam int          MAXC  = 260;
    localparam int          D_A   = 4;
    localparam int          D_B   = 0;
    localparam logic [31:0] TCODE = 32'hDEAD0001;

    logic        clk;
    logic        rstn;
    logic [63:0] lim_a, lim_b;
    logic        valid_a, valid_b;
    logic [31:0] code_a, code_b;
    logic        ready_a, ready_b;
    logic        done_a, done_b;
    logic [31:0] exit_a, exit_b;
    logic [63:0] cnt_a, cnt_b;

    bit          v_plan [MAXC];
    logic [31:0] c_plan [MAXC];
    logic [63:0] l_plan [MAXC];

    int n_checks;
    int n_err;

    sim_status_writer #(
        .CNT_W(64), .DRAIN_CYCLES(D_A), .TIMEOUT_CODE(TCODE), .FINISH(1'b0)
    ) u_dut_a (
        .clk(clk), .rstn(rstn), .timeout_limit(lim_a),
        .req_valid(valid_a), .req_ready(ready_a), .req_code(code_a),
        .done(done_a), .exit_code(exit_a), .cycle_count(cnt_a)
    );

    sim_status_writer #(
        .CNT_W(64), .DRAIN_CYCLES(D_B), .TIMEOUT_CODE(TCODE), .FINISH(1'b0)
    ) u_dut_b (
        .clk(clk), .rstn(rstn), .timeout_limit(lim_b),
        .req_valid(valid_b), .req_ready(ready_b), .req_code(code_b),
        .done(done_b), .exit_code(exit_b), .cycle_count(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_plans();
        for (int i = 0; i < MAXC; i++) begin
            v_plan[i] = 1'b0;
            c_plan[i] = 32'd0;
            l_plan[i] = 64'd0;
        end
    endtask

    // Hold reset for two falling edges, check the reset values of the selected instance, then release it just after a rising edge.
    task automatic do_reset(input int sel, input string name);
        rstn    = 1'b0;
        valid_a = 1'b0; valid_b = 1'b0;
        code_a  = 32'd0; code_b = 32'd0;
        lim_a   = 64'd0; lim_b  = 64'd0;
        repeat (2) @(negedge clk);
        chk($sformatf("%s/rst_ready", name), (sel == 0) ? {63'd0, ready_a} : {63'd0, ready_b}, 64'd1);
        chk($sformatf("%s/rst_done",  name), (sel == 0) ? {63'd0, done_a}  : {63'd0, done_b},  64'd0);
        chk($sformatf("%s/rst_code",  name), (sel == 0) ? {32'd0, exit_a}  : {32'd0, exit_b},  64'd0);
        chk($sformatf("%s/rst_cnt",   name), (sel == 0) ? cnt_a : cnt_b, 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Run cycles 0..ncyc-1 from the plans on the selected instance and check all outputs against the reference model.
    task automatic run_case(input int sel, input int ncyc, input string name);
        int          acc;
        logic [31:0] acc_code;
        int          d;
        bit          exp_ready, exp_done;
        logic [63:0] exp_cnt;
        logic [31:0] exp_code;

        d        = (sel == 0) ? D_A : D_B;
        acc      = -1;
        acc_code = 32'd0;
        for (int k = 0; k < ncyc; k++) begin
            if (v_plan[k]) begin
                acc = k; acc_code = c_plan[k]; break;
            end else if (l_plan[k] != 64'd0 && l_plan[k] == 64'(k)) begin
                acc = k; acc_code = TCODE; break;
            end
        end

        for (int k = 0; k < ncyc; k++) begin
            if (sel == 0) begin
                valid_a = v_plan[k]; code_a = c_plan[k]; lim_a = l_plan[k];
                valid_b = 1'b0;      code_b = 32'd0;     lim_b = 64'd0;
            end else begin
                valid_b = v_plan[k]; code_b = c_plan[k]; lim_b = l_plan[k];
                valid_a = 1'b0;      code_a = 32'd0;     lim_a = 64'd0;
            end
            @(negedge clk);
            exp_ready = (acc < 0) || (k <= acc);
            exp_done  = (acc >= 0) && (k >= acc + d + 2);
            exp_cnt   = ((acc < 0) || (k <= acc)) ? 64'(k) : 64'(acc);
            exp_code  = ((acc >= 0) && (k > acc)) ? acc_code : 32'd0;
            chk($sformatf("%s/c%0d/ready", name, k), (sel == 0) ? {63'd0, ready_a} : {63'd0, ready_b}, {63'd0, exp_ready});
            chk($sformatf("%s/c%0d/done",  name, k), (sel == 0) ? {63'd0, done_a}  : {63'd0, done_b},  {63'd0, exp_done});
            chk($sformatf("%s/c%0d/code",  name, k), (sel == 0) ? {32'd0, exit_a}  : {32'd0, exit_b},  {32'd0, exp_code});
            chk($sformatf("%s/c%0d/cnt",   name, k), (sel == 0) ? cnt_a : cnt_b, exp_cnt);
            @(posedge clk);
            #1;
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    initial begin
        int sel, p, chg, lim0, lim1;
        n_checks = 0;
        n_err    = 0;
        rstn     = 1'b0;
        valid_a  = 1'b0; valid_b = 1'b0;
        code_a   = 32'd0; code_b = 32'd0;
        lim_a    = 64'd0; lim_b  = 64'd0;

        // Pass: code 0 at cycle 10, watchdog off.
        clear_plans();
        v_plan[10] = 1'b1; c_plan[10] = 32'd0;
        do_reset(0, "pass");
        run_case(0, 22, "pass");

        // Timeout at 100 with no request.
        clear_plans();
        for (int i = 0; i < MAXC; i++) l_plan[i] = 64'd100;
        do_reset(0, "tmo");
        run_case(0, 110, "tmo");

        // Collision: the request wins over the watchdog in the same cycle.
        clear_plans();
        for (int i = 0; i < MAXC; i++) l_plan[i] = 64'd50;
        v_plan[50] = 1'b1; c_plan[50] = 32'd7;
        do_reset(0, "coll");
        run_case(0, 60, "coll");

        // Zero drain on instance B.
        clear_plans();
        v_plan[5] = 1'b1; c_plan[5] = 32'd3;
        do_reset(1, "zdrn");
        run_case(1, 12, "zdrn");

        // Late requests during DRAIN and HALT are ignored.
        clear_plans();
        v_plan[8]  = 1'b1; c_plan[8]  = 32'h11;
        v_plan[10] = 1'b1; c_plan[10] = 32'd9;
        v_plan[16] = 1'b1; c_plan[16] = 32'h22;
        do_reset(0, "late");
        run_case(0, 20, "late");

        // Reset in mid-DRAIN, then a normal request.
        clear_plans();
        v_plan[6] = 1'b1; c_plan[6] = 32'h55;
        do_reset(0, "mrst1");
        run_case(0, 9, "mrst1");
        clear_plans();
        v_plan[12] = 1'b1; c_plan[12] = 32'hABC;
        do_reset(0, "mrst2");
        run_case(0, 22, "mrst2");

        // Limit lowered below the current count never fires.
        clear_plans();
        for (int i = 20; i < MAXC; i++) l_plan[i] = 64'd5;
        v_plan[40] = 1'b1; c_plan[40] = 32'h40;
        do_reset(0, "below");
        run_case(0, 48, "below");

        // Limit changed mid-run takes effect immediately.
        clear_plans();
        for (int i = 0; i < MAXC; i++) l_plan[i] = (i < 30) ? 64'd200 : 64'd35;
        do_reset(1, "chg");
        run_case(1, 42, "chg");

        // Randomized cases: sparse requests, a limit that may change once, random instance.
        for (int t = 0; t < 16; t++) begin
            clear_plans();
            sel  = int'($urandom_range(0, 1));
            p    = int'($urandom_range(0, 3));
            chg  = int'($urandom_range(0, 150));
            lim0 = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(5, 150));
            lim1 = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(5, 150));
            for (int i = 0; i < MAXC; i++) begin
                v_plan[i] = ($urandom_range(0, 99) < p);
                c_plan[i] = $urandom;
                l_plan[i] = (i < chg) ? 64'(lim0) : 64'(lim1);
            end
            do_reset(sel, $sformatf("rnd%0d", t));
            run_case(sel, 200, $sformatf("rnd%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
